// File: rtl/uart_cmd_rx_if.sv
// Serial line in, received command byte and status pulses out.
// slave = the receiver, master = whatever drives the line and consumes cmd.
interface uart_cmd_rx_if;
  logic       rx;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       frame_err;

  modport master (output rx, input cmd, input cmd_valid, input frame_err);
  modport slave  (input rx, output cmd, output cmd_valid, output frame_err);
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 command receiver: cmd/cmd_valid update on the edge after the mid-stop-bit sample (rx is 2-flop synchronised first).
// No backpressure: cmd_valid is a one-cycle pulse and cmd simply holds the last good byte.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic          clk,
  input  logic          rst,
  uart_cmd_rx_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          sync1_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // Half a bit in: still low means a real start bit, else a glitch.
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s_q) begin
            cmd_d       = shreg_q;
            cmd_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= bus.rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: an event-queue model of expected pulses checked every cycle,
// plus literal expectations after each directed scenario.
module tb_uart_cmd_rx;

  localparam int CPB     = 16;
  localparam int CPB_DEF = 434;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_rx_if bus16();
  uart_cmd_rx_if bus434();

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  uart_cmd_rx dut434 (.clk(clk), .rst(rst), .bus(bus434));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         is_err;
    logic [7:0] val;
  } ev_t;
  ev_t        exp_q[$];
  ev_t        cur_ev;
  logic [7:0] model_cmd = 8'h00;
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         v434 = 0, e434 = 0, v434_at = 0, start434 = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Every good frame must raise cmd_valid, every bad one frame_err, at the
  // mid-stop-bit time plus the synchroniser and output register delay.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cmd", {24'd0, bus16.cmd}, 32'h00);
      chk("rst_cmd_valid", {31'd0, bus16.cmd_valid}, 32'd0);
      chk("rst_frame_err", {31'd0, bus16.frame_err}, 32'd0);
      model_cmd = 8'h00;
      exp_q.delete();
    end else begin
      chk("valid_err_exclusive", {31'd0, bus16.cmd_valid & bus16.frame_err}, 32'd0);
      if (bus16.cmd_valid) valid_cnt++;
      if (bus16.frame_err) err_cnt++;
      if (bus16.cmd_valid || bus16.frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, bus16.cmd_valid, bus16.frame_err}, 32'd0);
        end else begin
          cur_ev = exp_q.pop_front();
          chk("pulse_cycle", cyc, cur_ev.at);
          chk("pulse_kind_err", {31'd0, bus16.frame_err}, {31'd0, cur_ev.is_err});
          if (!cur_ev.is_err) model_cmd = cur_ev.val;
        end
      end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        cur_ev = exp_q.pop_front();
        chk("missed_pulse", {30'd0, bus16.cmd_valid, bus16.frame_err},
            cur_ev.is_err ? 32'd1 : 32'd2);
      end
      chk("cmd_model", {24'd0, bus16.cmd}, {24'd0, model_cmd});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus434.cmd_valid) begin
        v434++;
        v434_at = cyc;
      end
      if (bus434.frame_err) e434++;
    end
  end

  task automatic set_rx(input bit sel, input logic b);
    if (sel) bus434.rx = b;
    else     bus16.rx  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling clock edge; kind: 0 no event expected, 1 good byte, 2 frame error.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop,
                            input int kind, input int jit);
    logic [9:0] fr;
    int         per;
    ev_t        ev;
    fr  = {stop, d, 1'b0};
    per = sel ? (CPB_DEF + jit) : CPB;
    if (sel) start434 = cyc;
    if (!sel && kind != 0) begin
      ev.at     = cyc + 3 + CPB / 2 + 9 * CPB;
      ev.is_err = (kind == 2);
      ev.val    = d;
      exp_q.push_back(ev);
    end
    for (int i = 0; i < 10; i++) begin
      set_rx(sel, fr[i]);
      repeat (per) @(negedge clk);
    end
  endtask

  initial begin
    bus16.rx  = 1'b1;
    bus434.rx = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle(4);

    // Single good byte
    send_frame(0, 8'h31, 1'b1, 1, 0);
    idle(20);
    chk("t1_cmd", {24'd0, bus16.cmd}, 32'h31);
    chk("t1_valid_cnt", valid_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);

    // Back-to-back, no idle gap
    send_frame(0, 8'h34, 1'b1, 1, 0);
    chk("t2_first_cmd", {24'd0, bus16.cmd}, 32'h34);
    send_frame(0, 8'h30, 1'b1, 1, 0);
    idle(5);
    chk("t2_second_cmd", {24'd0, bus16.cmd}, 32'h30);
    chk("t2_valid_cnt", valid_cnt, 3);
    chk("t2_err_cnt", err_cnt, 0);

    // Short low glitch
    set_rx(0, 1'b0);
    idle(4);
    set_rx(0, 1'b1);
    idle(40);
    chk("t3_cmd", {24'd0, bus16.cmd}, 32'h30);
    chk("t3_valid_cnt", valid_cnt, 3);
    chk("t3_err_cnt", err_cnt, 0);

    // Bad stop bit, break, then a good byte
    send_frame(0, 8'h32, 1'b0, 2, 0);
    idle(40);
    set_rx(0, 1'b1);
    idle(20);
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_cmd_kept", {24'd0, bus16.cmd}, 32'h30);
    send_frame(0, 8'h33, 1'b1, 1, 0);
    idle(10);
    chk("t4_cmd", {24'd0, bus16.cmd}, 32'h33);
    chk("t4_valid_cnt", valid_cnt, 4);

    // Reset in the middle of data bit 3
    fork
      send_frame(0, 8'h35, 1'b1, 0, 0);
      begin
        idle(CPB * 4 + CPB / 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cmd", {24'd0, bus16.cmd}, 32'h00);
      end
    join
    idle(3);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle(10);
    chk("t5_valid_cnt", valid_cnt, 4);
    chk("t5_err_cnt", err_cnt, 1);
    send_frame(0, 8'h36, 1'b1, 1, 0);
    idle(10);
    chk("t5_cmd", {24'd0, bus16.cmd}, 32'h36);
    chk("t5_valid_cnt_after", valid_cnt, 5);

    // Default rate, bit periods stretched then shrunk by about 2%
    chk("t6_pre_valid", v434, 0);
    send_frame(1, 8'h31, 1'b1, 0, 8);
    idle(20);
    chk("t6_slow_valid_cnt", v434, 1);
    chk("t6_slow_cmd", {24'd0, bus434.cmd}, 32'h31);
    chk("t6_slow_cycle", v434_at, start434 + 3 + CPB_DEF / 2 + 9 * CPB_DEF);
    send_frame(1, 8'h31, 1'b1, 0, -8);
    idle(20);
    chk("t6_fast_valid_cnt", v434, 2);
    chk("t6_fast_cmd", {24'd0, bus434.cmd}, 32'h31);
    chk("t6_fast_cycle", v434_at, start434 + 3 + CPB_DEF / 2 + 9 * CPB_DEF);
    chk("t6_err_cnt", e434, 0);

    chk("expected_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port cmd  output  8  last correctly received byte, held until the next good byte; drives the downstream command decoder directly.
REQ-006 SHALL have port cmd_valid  output  1  one-cycle pulse marking the cycle cmd updates.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-008 SHALL pass rx through a two-flop synchronizer (both flops reset to 1); all decisions use the second-stage output (rx_s).
REQ-009 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK with a bit-time counter (width ceil(log2(CLKS_PER_BIT))) and a 3-bit bit index.
REQ-010 IDLE: on rx_s == 0, SHALL clear the counter and enter START.
REQ-011 START: SHALL count to CLKS_PER_BIT/2 - 1 (integer division), then sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-012 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (mid-bit), shifting into an internal shift register LSB first; after the 8th sample -> STOP.
REQ-013 STOP: after CLKS_PER_BIT cycles SHALL sample rx_s; 1 -> load cmd from the shift register, pulse cmd_valid, enter IDLE; 0 -> pulse frame_err, leave cmd unchanged, enter BREAK.
REQ-014 BREAK: SHALL remain until rx_s == 1, then enter IDLE; no start detection while in BREAK.
REQ-015 cmd and cmd_valid SHALL be registered; cmd_valid and the new cmd value SHALL appear together, on the clock edge following the stop-bit sample, high for exactly one cycle.
REQ-016 cmd_valid and frame_err SHALL never be asserted in the same cycle.
REQ-017 Back-to-back frames: SHALL return to IDLE immediately after the stop sample, so a start bit beginning half a bit period later is detected with no byte lost.
REQ-018 The shift register SHALL NOT alter cmd until a valid stop bit; partial or errored frames SHALL never reach cmd.
REQ-019 rx activity during START/DATA/STOP other than the scheduled samples SHALL be ignored (no resynchronisation mid-frame).

Reset
REQ-020 On rst high, SHALL asynchronously set: FSM = IDLE, counters = 0, shift register = 0, synchronizer flops = 1, cmd = 8'h00, cmd_valid = 0, frame_err = 0.
REQ-021 cmd reset value 8'h00 SHALL match no decoder command, so the downstream selection stays at its power-up default.
REQ-022 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait in IDLE for a fresh falling edge.

Verification (CLKS_PER_BIT = 16 unless noted)
REQ-023 Send 8'h31 ('1') as 8N1 at 16 clks/bit -> cmd = 8'h31 with a single one-cycle cmd_valid pulse, frame_err stays 0, cmd holds 8'h31 afterwards.
REQ-024 Send 8'h34 then 8'h30 back-to-back (no idle gap) -> two cmd_valid pulses, cmd = 8'h34 then 8'h30, no frame_err.
REQ-025 Drive rx low for 4 cycles then high -> FSM returns to IDLE; no cmd_valid or frame_err; cmd unchanged.
REQ-026 Send 8'h32 with stop bit forced low and rx held low 40 cycles, then high, then a good 8'h33 -> one frame_err pulse, cmd unchanged by the bad frame, then cmd = 8'h33 with cmd_valid.
REQ-027 Assert rst during the 4th data bit of 8'h35, release, then send 8'h36 -> all outputs at reset values during rst, no pulse for the aborted frame, cmd = 8'h36 after the second frame.
REQ-028 Repeat REQ-023 with default CLKS_PER_BIT = 434 and bit-period jitter of +/-2% -> cmd = 8'h31, cmd_valid pulses once.
